fpu_writeback_queue: RTL
========================

FPU_WRITEBACK_QUEUE -- requirements
Module: fpu_writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2..16.
REQ-002 Parameter TAG_W, default 5, destination register index width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  FPU result present this cycle; driven by the FPU valid output.
REQ-006 in_result  input  32  FPU result word.
REQ-007 in_rd  input  TAG_W  destination register index for in_result.
REQ-008 wb_ready  input  1  register-file write port free this cycle.
REQ-009 wb_en  output  1  head entry offered for writeback.
REQ-010 wb_rd  output  TAG_W  head entry destination index.
REQ-011 wb_data  output  32  head entry data.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 count  output  $clog2(DEPTH)+1  occupied entries.
REQ-015 overflow  output  1  sticky; a result was lost because the queue was full.

Function
REQ-016 Circular FIFO: DEPTH entries of {rd, data}, write pointer, read pointer, explicit count register; pointers wrap from DEPTH-1 to 0.
REQ-017 wb_en SHALL equal !empty combinationally from registered state; wb_rd/wb_data SHALL show the head entry when !empty and 0 when empty.
REQ-018 pop SHALL occur on a cycle with wb_en && wb_ready; read pointer advances by one and the next entry appears on wb_* in the following cycle.
REQ-019 push SHALL occur on a cycle with in_valid && in_rd != 0 && (!full || pop); the entry is written at the write pointer, which advances by one.
REQ-020 in_valid with in_rd == 0 SHALL be discarded (x0 write): no push, no count change, no overflow.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including when full (a slot is freed and refilled in the same cycle) and when count == 1.
REQ-022 Push while empty: entry SHALL first appear on wb_* the cycle after the push edge (one-cycle latency, no bypass).
REQ-023 in_valid && in_rd != 0 && full && !pop SHALL drop the result, leave all entries unchanged, and set overflow at that edge.
REQ-024 overflow SHALL stay 1 until reset; no other clear path.
REQ-025 count SHALL update +1 push-only, -1 pop-only, 0 otherwise; it SHALL never exceed DEPTH or go below 0.
REQ-026 wb_ready SHALL be ignored while empty; no pointer moves.
REQ-027 Entry order at the write port SHALL equal accepted push order; no reordering, no merging of same-rd entries.

Reset
REQ-028 While reset is high, regardless of clk: pointers = 0, count = 0, overflow = 0, so empty = 1, full = 0, wb_en = 0, wb_rd = 0, wb_data = 0.
REQ-029 Reset asserted mid-operation SHALL discard every queued entry immediately; no writeback of pre-reset data after release.
REQ-030 Entry storage needs no reset; it SHALL be unobservable while empty.
REQ-031 The first push SHALL be accepted on the first rising clk edge after reset deasserts.

Verification
REQ-032 Reset, then push {rd=3, 0x3F800000} with wb_ready=0 -> next cycle wb_en=1, wb_rd=3, wb_data=0x3F800000, count=1; hold wb_ready=0 -> outputs stable.
REQ-033 Push 4 entries (rd 1..4, data 0x11..0x44), wb_ready=0 -> full=1, count=4; 5th push rd=5 -> dropped, overflow=1, count=4; then wb_ready=1 for 4 cycles -> wb_rd sequence 1,2,3,4, empty=1, overflow still 1.
REQ-034 Full queue, push rd=6 data 0x66 with wb_ready=1 on the same cycle -> head rd=1 written, count stays 4, overflow unchanged, rd=6 drains last.
REQ-035 in_valid=1, in_rd=0, data 0xDEADBEEF on an empty queue -> empty stays 1, count=0, overflow=0.
REQ-036 Continuous push and pop every cycle for 20 cycles (rd cycling 1..31, data = cycle index) -> count stays 1 after the first, wb_data in order, pointers wrap without loss.
REQ-037 Queue holding 3 entries, reset pulsed between clock edges -> wb_en=0, count=0 asynchronously; after release wb_en stays 0 until a new push.

Source files
------------

// File: rtl/fpu_writeback_queue.sv
// FPU result queue feeding the FP register-file write port; one-cycle latency from push to wb_*,
// head is held until wb_ready; results arriving while full are dropped and flagged in sticky overflow.
module fpu_writeback_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [31:0]              in_result,
   input  logic [TAG_W-1:0]         in_rd,
   input  logic                     wb_ready,
   output logic                     wb_en,
   output logic [TAG_W-1:0]         wb_rd,
   output logic [31:0]              wb_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [TAG_W-1:0] rd_mem   [DEPTH];
   logic [31:0]      data_mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             req;
   logic             push;
   logic             pop;
   logic             drop;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign wb_en = !empty;

   // x0 destinations are architecturally discarded, so they never occupy a slot
   assign req  = in_valid && (in_rd != '0);
   assign pop  = wb_en && wb_ready;
   assign push = req && (!full || pop);
   assign drop = req && full && !pop;

   assign wb_rd   = empty ? '0 : rd_mem[rd_ptr];
   assign wb_data = empty ? '0 : data_mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
         if (drop) overflow <= 1'b1;
      end
   end

   // Storage is not reset; it is masked on the outputs whenever the queue is empty
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wr_ptr]   <= in_rd;
         data_mem[wr_ptr] <= in_result;
      end
   end

endmodule
